axicb_scfifo_ctrl: RTL and testbench
====================================

Name: axicb_scfifo_ctrl

Overview:
Control stage of the crossbar's single-clock FIFO. Owns write/read pointers, occupancy and flow control, and drives the external dual-port RAM's write and read ports. Presents valid/ready push and pop interfaces with first-word-fall-through output through a 2-entry output buffer. Handles either RAM read latency (combinational or registered) so throughput stays at 1 word/cycle.

Parameters:
ADDR_WIDTH, 8, RAM address width; RAM capacity is 2**ADDR_WIDTH words.
DATA_WIDTH, 8, payload width.
FFD_EN, 0, RAM read latency: 0 = ram_data_out valid in the same cycle as ram_addr_out; 1 = valid one cycle after.

Ports:
aclk  in  1  clock, all logic on rising edge.
aresetn  in  1  asynchronous active-low reset.
srst  in  1  synchronous clear, active-high, same effect as reset.
in_valid  in  1  push request.
in_ready  out  1  push accepted when in_valid & in_ready.
in_data  in  DATA_WIDTH  push payload.
out_valid  out  1  head word available.
out_ready  in  1  pop when out_valid & out_ready.
out_data  out  DATA_WIDTH  head word.
full  out  1  RAM holds 2**ADDR_WIDTH words (equals !in_ready).
empty  out  1  level == 0.
level  out  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer).
ram_wr_en  out  1  RAM write strobe.
ram_addr_in  out  ADDR_WIDTH  RAM write address.
ram_data_in  out  DATA_WIDTH  RAM write data.
ram_addr_out  out  ADDR_WIDTH  RAM read address.
ram_data_out  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (aresetn low, async) or srst high at edge: wr_ptr=rd_ptr=0, in-flight flag=0, buffer count=0; outputs out_valid=0, out_data=0, full=0, empty=1, level=0, in_ready=1. An in-flight read is discarded.
- Pointers wr_ptr, rd_ptr are ADDR_WIDTH+1 bits; ram_cnt = wr_ptr - rd_ptr (mod 2**(ADDR_WIDTH+1)); wrap of lower ADDR_WIDTH bits is natural.
- full = (ram_cnt == 2**ADDR_WIDTH); in_ready = !full, from registered state only (no dependency on out_ready).
- Push: ram_wr_en = in_valid & in_ready (combinational); ram_addr_in = wr_ptr[ADDR_WIDTH-1:0]; ram_data_in = in_data; wr_ptr increments at the edge.
- Fetch: ram_addr_out = rd_ptr[ADDR_WIDTH-1:0] at all times. fetch = (ram_cnt != 0) & (buf_cnt + inflight - pop < 2), where pop = out_valid & out_ready. On fetch rd_ptr increments.
- FFD_EN=0: on a fetch, ram_data_out is written into the buffer at the same edge.
- FFD_EN=1: a fetch sets inflight; the next cycle ram_data_out is written into the buffer and inflight clears, unless a new fetch sets it again.
- Output buffer: 2-entry FIFO of registers; out_valid = buf_cnt != 0; out_data = head entry. Pop and capture in the same cycle are both honoured, and order is preserved.
- Because fetch uses the registered ram_cnt, a word written at edge t is first fetched in the cycle after t. No RAM read-during-write hazard exists.
- Latency from the push-accept edge to out_valid high: 1 cycle (FFD_EN=0), 2 cycles (FFD_EN=1) when the FIFO is empty.
- Throughput: a sustained push with a sustained pop (out_ready=1) gives 1 word/cycle in both modes.
- level = ram_cnt + inflight + buf_cnt, registered-state derived; max 2**ADDR_WIDTH+2. empty = (level==0).
- Simultaneous push and pop when full: push is refused (in_ready=0). The pop proceeds, and in_ready rises the cycle after a fetch frees a RAM slot.
- Pop when out_valid=0: ignored. in_data is don't-care when in_valid=0.

Test Plan:
- Reset mid-stream: after 5 pushes assert aresetn low for one cycle -> out_valid=0, level=0, empty=1, full=0, in_ready=1 immediately; subsequent pushes 0xA1,0xA2 pop out as 0xA1,0xA2.
- Single word, ADDR_WIDTH=3, FFD_EN=0 then 1: push 0x5C at edge t -> out_valid=1, out_data=0x5C after edge t+1 (FFD_EN=0) / t+2 (FFD_EN=1); level=1, then 0 after pop.
- Fill, ADDR_WIDTH=3, out_ready=0: push 0x00..0x0C -> 10 accepted (8 RAM + 2 buffer), full=1, in_ready=0, level=10; further pushes refused.
- Drain from full: raise out_ready -> data 0x00..0x09 in order, no gaps after the first; full deasserts within 2 cycles of the first pop; end with empty=1.
- Streaming, both FFD_EN values: continuous push and pop of 1000 incrementing words -> one word per cycle, in order, with level constant at steady state.
- Random valid/ready at 50% each, 10k words, ADDR_WIDTH=2 (pointer wrap stress) -> scoreboard matches; level never exceeds 6; ram_wr_en never asserted while full.

Source files
------------

// File: rtl/axicb_scfifo_ctrl.sv
// axicb_scfifo_ctrl: pointer, occupancy and flow control for a single-clock FIFO built on an external
// dual-port RAM, with a 2-entry first-word-fall-through output buffer hiding the RAM read latency.
module axicb_scfifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FFD_EN = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_in,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, ram_cnt;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic [1:0] buf_cnt, buf_left;
  logic inflight, push, pop, fetch, capture;
  assign ram_cnt = wr_ptr - rd_ptr;
  assign full = ram_cnt[ADDR_WIDTH];
  assign in_ready = !full;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  // Only fetch when the word is guaranteed a free buffer slot on arrival.
  assign fetch = (ram_cnt != '0) && (({1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  assign capture = (FFD_EN != 0) ? inflight : fetch;
  assign buf_left = buf_cnt - {1'b0, pop};
  assign out_valid = buf_cnt != 2'd0;
  assign out_data = buf0;
  assign level = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(inflight) + (ADDR_WIDTH+2)'(buf_cnt);
  assign empty = level == '0;
  assign ram_wr_en = push;
  assign ram_addr_in = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_data_in = in_data;
  assign ram_addr_out = rd_ptr[ADDR_WIDTH-1:0];
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      inflight <= 1'b0;
      buf_cnt <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      inflight <= 1'b0;
      buf_cnt <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(push);
      rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(fetch);
      inflight <= (FFD_EN != 0) && fetch;
      buf_cnt <= buf_left + {1'b0, capture};
      if (pop) buf0 <= buf1;
      if (capture && buf_left == 2'd0) buf0 <= ram_data_out;
      if (capture && buf_left != 2'd0) buf1 <= ram_data_out;
    end
  end
endmodule

// File: tb/tb_axicb_scfifo_ctrl.sv
// tb_axicb_scfifo_ctrl: three controllers (AW3/comb read, AW3/registered read, AW2/registered read)
// share one stimulus stream, each with its own RAM model and reference queue.
module tb_axicb_scfifo_ctrl;
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn = 1'b0, srst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [2:0] ir, ov, fl, em, we;
  logic [2:0][7:0] od, wd;
  logic [7:0] rdo_a, rdo_b, rdo_c;
  logic [4:0] lv_a, lv_b;
  logic [3:0] lv_c;
  logic [2:0] wa_a, wa_b, ra_a, ra_b;
  logic [1:0] wa_c, ra_c;
  logic [7:0] mem_a[8], mem_b[8], mem_c[4];
  assign rdo_a = mem_a[ra_a];
  always @(posedge aclk) begin
    if (we[0]) mem_a[wa_a] <= wd[0];
    if (we[1]) mem_b[wa_b] <= wd[1];
    if (we[2]) mem_c[wa_c] <= wd[2];
    rdo_b <= mem_b[ra_b];
    rdo_c <= mem_c[ra_c];
  end
  axicb_scfifo_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FFD_EN(0)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .full(fl[0]),
    .empty(em[0]), .level(lv_a), .ram_wr_en(we[0]), .ram_addr_in(wa_a), .ram_data_in(wd[0]),
    .ram_addr_out(ra_a), .ram_data_out(rdo_a));
  axicb_scfifo_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FFD_EN(1)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .full(fl[1]),
    .empty(em[1]), .level(lv_b), .ram_wr_en(we[1]), .ram_addr_in(wa_b), .ram_data_in(wd[1]),
    .ram_addr_out(ra_b), .ram_data_out(rdo_b));
  axicb_scfifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FFD_EN(1)) dut_c (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .full(fl[2]),
    .empty(em[2]), .level(lv_c), .ram_wr_en(we[2]), .ram_addr_in(wa_c), .ram_data_in(wd[2]),
    .ram_addr_out(ra_c), .ram_data_out(rdo_c));
  typedef struct {
    logic iv; logic [7:0] d; logic rdy;
    logic e_ir; logic e_ov; logic [7:0] e_od; int e_lv; logic e_full;
    logic b_ov; logic [7:0] b_od; int b_lv;
  } vec_t;
  vec_t tbl[$];
  int passed = 0, total = 0;
  logic [7:0] sb[3][1024];
  int hd[3], tl[3], pops[3];
  function automatic vec_t mk(logic iv, logic [7:0] d, logic rdy, logic e_ir, logic e_ov,
                              logic [7:0] e_od, int e_lv, logic e_full, logic b_ov,
                              logic [7:0] b_od, int b_lv);
    vec_t r;
    r.iv = iv; r.d = d; r.rdy = rdy; r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od;
    r.e_lv = e_lv; r.e_full = e_full; r.b_ov = b_ov; r.b_od = b_od; r.b_lv = b_lv;
    return r;
  endfunction
  function automatic int lvl(int i);
    return (i == 0) ? int'(lv_a) : (i == 1) ? int'(lv_b) : int'(lv_c);
  endfunction
  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
  endtask
  // Compare every controller against its reference queue, then advance one cycle.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      int l, exp_d;
      l = lvl(i);
      chk("level", i, l, tl[i] - hd[i]);
      chk("empty", i, int'(em[i]), int'(tl[i] == hd[i]));
      chk("in_ready_vs_full", i, int'(ir[i]), int'(!fl[i]));
      chk("write_while_full", i, int'(we[i] && fl[i]), 0);
      if (i == 2) chk("level_max", i, int'(l <= 6), 1);
      if (ov[i] && out_ready) begin
        exp_d = (tl[i] == hd[i]) ? -1 : int'(sb[i][hd[i] % 1024]);
        chk("pop_data", i, int'(od[i]), exp_d);
        if (tl[i] != hd[i]) hd[i]++;
        pops[i]++;
      end
      if (in_valid && ir[i]) begin
        sb[i][tl[i] % 1024] = in_data;
        tl[i]++;
      end
    end
    @(posedge aclk);
    if (srst) for (int i = 0; i < 3; i++) hd[i] = tl[i];
    @(negedge aclk);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n[2], first[2], last[2], base[3], steady[3], got[$], cyc;
    for (int i = 0; i < 3; i++) begin hd[i] = 0; tl[i] = 0; pops[i] = 0; end
    tbl.push_back(mk(1, 8'h5C, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h5C, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1, 8'h5C, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    for (int k = 0; k < 13; k++)
      tbl.push_back(mk(1, 8'(k), 0, k <= 9, k >= 2, 8'h00, (k > 9) ? 10 : k, k >= 10,
                       k >= 3, 8'h00, (k > 9) ? 10 : k));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 10, 1, 1, 8'h00, 10));
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", i, int'(ov[i]), 0);
      chk("rst_out_data", i, int'(od[i]), 0);
      chk("rst_level", i, lvl(i), 0);
      chk("rst_empty", i, int'(em[i]), 1);
      chk("rst_full", i, int'(fl[i]), 0);
      chk("rst_in_ready", i, int'(ir[i]), 1);
    end
    foreach (tbl[k]) begin
      drive(tbl[k].iv, tbl[k].d, tbl[k].rdy);
      for (int i = 0; i < 2; i++) begin
        chk("tbl_in_ready", k, int'(ir[i]), int'(tbl[k].e_ir));
        chk("tbl_full", k, int'(fl[i]), int'(tbl[k].e_full));
      end
      chk("tbl_a_out_valid", k, int'(ov[0]), int'(tbl[k].e_ov));
      if (tbl[k].e_ov) chk("tbl_a_out_data", k, int'(od[0]), int'(tbl[k].e_od));
      chk("tbl_a_level", k, int'(lv_a), tbl[k].e_lv);
      chk("tbl_b_out_valid", k, int'(ov[1]), int'(tbl[k].b_ov));
      if (tbl[k].b_ov) chk("tbl_b_out_data", k, int'(od[1]), int'(tbl[k].b_od));
      chk("tbl_b_level", k, int'(lv_b), tbl[k].b_lv);
      step();
    end
    for (int i = 0; i < 2; i++) begin n[i] = 0; first[i] = -1; last[i] = -1; end
    for (int c = 0; c < 20; c++) begin
      drive(0, 8'h00, 1);
      for (int i = 0; i < 2; i++) begin
        if (ov[i]) begin
          chk("drain_order", i, int'(od[i]), n[i]);
          n[i]++;
          if (first[i] < 0) first[i] = c;
          last[i] = c;
        end
        if (first[i] >= 0 && c == first[i] + 2) chk("drain_full_released", i, int'(fl[i]), 0);
      end
      step();
    end
    drive(0, 8'h00, 0);
    for (int i = 0; i < 2; i++) begin
      chk("drain_count", i, n[i], 10);
      chk("drain_no_gaps", i, last[i] - first[i], 9);
      chk("drain_empty", i, int'(em[i]), 1);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1, 8'(8'h10 + k), 0);
      step();
    end
    aresetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_out_valid", i, int'(ov[i]), 0);
      chk("async_rst_level", i, lvl(i), 0);
      chk("async_rst_empty", i, int'(em[i]), 1);
      chk("async_rst_full", i, int'(fl[i]), 0);
      chk("async_rst_in_ready", i, int'(ir[i]), 1);
      hd[i] = tl[i];
    end
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(c < 2, (c == 0) ? 8'hA1 : 8'hA2, 1);
      if (ov[0]) got.push_back(int'(od[0]));
      step();
    end
    chk("post_rst_count", 0, got.size(), 2);
    if (got.size() == 2) begin
      chk("post_rst_first", 0, got[0], 'hA1);
      chk("post_rst_second", 0, got[1], 'hA2);
    end
    for (int i = 0; i < 3; i++) base[i] = pops[i];
    for (int c = 0; c < 1000; c++) begin
      drive(1, 8'(c), 1);
      if (c >= 12) for (int i = 0; i < 3; i++) begin
        chk("stream_out_valid", i, int'(ov[i]), 1);
        if (c == 12) steady[i] = lvl(i);
        else chk("stream_level_const", i, lvl(i), steady[i]);
      end
      step();
    end
    for (int c = 0; c < 12; c++) begin drive(0, 8'h00, 1); step(); end
    for (int i = 0; i < 3; i++) chk("stream_words", i, pops[i] - base[i], 1000);
    base[2] = pops[2];
    cyc = 0;
    while (pops[2] - base[2] < 10000 && cyc < 40000) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step();
      cyc++;
    end
    chk("random_words_done", 2, int'(pops[2] - base[2] >= 10000), 1);
    for (int c = 0; c < 12; c++) begin drive(0, 8'h00, 1); step(); end
    for (int k = 0; k < 3; k++) begin drive(1, 8'(8'h40 + k), 0); step(); end
    srst = 1'b1;
    drive(0, 8'h00, 0);
    step();
    srst = 1'b0;
    drive(0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      chk("srst_empty", i, int'(em[i]), 1);
      chk("srst_out_valid", i, int'(ov[i]), 0);
      chk("srst_level", i, lvl(i), 0);
    end
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
